cam_capture_seq: RTL and testbench

Frame-capture sequencer for the OV7670 capture path. Arms on a user start, aligns to the camera's VSYNC/HREF framing and pairs bytes into pixels. Generates the frame-buffer write address and write strobe for the RGB565→RGB332 byte-packing datapath, and checks frame geometry. Reports BUSY/DONE/ERR status to the top level and VGA side; supports single-shot and continuous capture.

---
 rtl/cam_pkg.sv | 32 +++
 rtl/cam_sync_edge.sv | 30 +++
 rtl/cam_capture_seq.sv | 141 ++++++++++++++
 tb/tb_cam_capture_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: sequencer states, default
// frame geometry and the RGB565 -> RGB332 packing used by the datapath.
package cam_pkg;

  localparam int H_PIX_DEF   = 160;
  localparam int V_LINES_DEF = 120;
  localparam int AW_DEF      = 17;
  localparam int FCW_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SYNC   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } cap_state_t;

  // RGB565 arrives as RRRRRGGG then GGGBBBBB; RGB332 keeps the top bits of each.
  localparam int RGB332_R_HI = 7;
  localparam int RGB332_R_LO = 5;
  localparam int RGB332_G_HI = 2;
  localparam int RGB332_G_LO = 0;
  localparam int RGB332_B_HI = 4;
  localparam int RGB332_B_LO = 3;

  function automatic logic [7:0] rgb332_pack(input logic [7:0] b_hi, input logic [7:0] b_lo);
    return {b_hi[RGB332_R_HI:RGB332_R_LO], b_hi[RGB332_G_HI:RGB332_G_LO],
            b_lo[RGB332_B_HI:RGB332_B_LO]};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registered copies of the camera framing strobes and the edge pulses the
// sequencer steps on.
module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  output logic vs_rise,
  output logic vs_fall,
  output logic hr_fall
);

  logic vs_q;
  logic hr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
    end else begin
      vs_q <= vsync;
      hr_q <= href;
    end
  end

  assign vs_rise = vsync & ~vs_q;
  assign vs_fall = ~vsync & vs_q;
  assign hr_fall = ~href & hr_q;

endmodule

// File: rtl/cam_capture_seq.sv
// Frame-capture sequencer: arms on START, aligns to whole frames, pairs bytes
// into pixels, drives frame-buffer WE/ADDR and checks frame geometry.
module cam_capture_seq
  import cam_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int AW      = AW_DEF,
  parameter int FCW     = FCW_DEF
) (
  input  logic           PCLK,
  input  logic           RSTn,
  input  logic           VSYNC,
  input  logic           HREF,
  input  logic           START,
  input  logic           CONT,
  input  logic           ABORT,
  output logic           BYTE_HI,
  output logic           WE,
  output logic [AW-1:0]  ADDR,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR,
  output logic [FCW-1:0] FRAME_CNT
);

  localparam int RW = $clog2(V_LINES + 2);
  localparam int CW = $clog2(H_PIX + 1);
  localparam logic [CW-1:0] COL_END   = CW'(H_PIX);
  localparam logic [RW-1:0] ROW_END   = RW'(V_LINES);
  localparam logic [RW-1:0] ROW_SAT   = RW'(V_LINES + 1);
  localparam logic [AW-1:0] LINE_STEP = AW'(H_PIX);

  cap_state_t     state;
  logic [RW-1:0]  row;
  logic [RW-1:0]  row_nxt;
  logic [CW-1:0]  col;
  logic [AW-1:0]  line_base;
  logic           phase;
  logic           len_err;
  logic           len_nxt;
  logic           cont_r;
  logic [FCW-1:0] fcnt;
  logic           vs_rise;
  logic           vs_fall;
  logic           hr_fall;
  logic           act;
  logic           in_range;

  cam_sync_edge u_edge (
    .clk     (PCLK),
    .rst_n   (RSTn),
    .vsync   (VSYNC),
    .href    (HREF),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall),
    .hr_fall (hr_fall)
  );

  // WE fires in the cycle of the second byte so the datapath writes on that edge.
  assign act      = (state == ST_ACTIVE) && !ABORT;
  assign in_range = (col < COL_END) && (row < ROW_END);
  assign WE       = act & HREF & phase & in_range;
  assign BYTE_HI  = act & HREF & ~phase;
  assign ADDR     = WE ? (line_base + AW'(col)) : '0;

  assign BUSY      = (state == ST_ARM) || (state == ST_SYNC) || (state == ST_ACTIVE);
  assign DONE      = (state == ST_DONE);
  assign ERR       = (state == ST_ERROR);
  assign FRAME_CNT = fcnt;

  // Row/length view after this cycle's line end, so a coincident frame end sees it.
  always_comb begin
    row_nxt = row;
    len_nxt = len_err;
    if (HREF && phase && (col >= COL_END)) len_nxt = 1'b1;
    if (hr_fall) begin
      if ((col != COL_END) || phase) len_nxt = 1'b1;
      if (row < ROW_SAT) row_nxt = row + RW'(1);
    end
  end

  always_ff @(posedge PCLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      line_base <= '0;
      phase     <= 1'b0;
      len_err   <= 1'b0;
      cont_r    <= 1'b0;
      fcnt      <= '0;
    end else if (ABORT) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (START) begin
            state  <= ST_ARM;
            cont_r <= CONT;
          end
        end
        ST_ARM: begin
          if (vs_rise) state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (vs_fall) begin
            state     <= ST_ACTIVE;
            row       <= '0;
            col       <= '0;
            line_base <= '0;
            phase     <= 1'b0;
            len_err   <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          row     <= row_nxt;
          len_err <= len_nxt;
          if (HREF) begin
            phase <= ~phase;
            if (phase && (col < COL_END)) col <= col + CW'(1);
          end else if (hr_fall) begin
            col   <= '0;
            phase <= 1'b0;
            if (row < ROW_END) line_base <= line_base + LINE_STEP;
          end
          if (vs_rise) begin
            if ((row_nxt == ROW_END) && !len_nxt) begin
              fcnt  <= fcnt + FCW'(1);
              state <= cont_r ? ST_SYNC : ST_DONE;
            end else begin
              state <= ST_ERROR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_seq.sv
// Directed bench for cam_capture_seq with a 4x3 frame: framing scenarios,
// geometry errors, continuous mode, abort and asynchronous reset.
module tb_cam_capture_seq;

  localparam int H_PIX   = 4;
  localparam int V_LINES = 3;
  localparam int AW      = 17;
  localparam int FCW     = 8;

  logic           PCLK;
  logic           RSTn;
  logic           VSYNC;
  logic           HREF;
  logic           START;
  logic           CONT;
  logic           ABORT;
  logic           BYTE_HI;
  logic           WE;
  logic [AW-1:0]  ADDR;
  logic           BUSY;
  logic           DONE;
  logic           ERR;
  logic [FCW-1:0] FRAME_CNT;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  int n_checks;
  int n_fail;

  cam_capture_seq #(
    .H_PIX   (H_PIX),
    .V_LINES (V_LINES),
    .AW      (AW),
    .FCW     (FCW)
  ) dut (
    .PCLK      (PCLK),
    .RSTn      (RSTn),
    .VSYNC     (VSYNC),
    .HREF      (HREF),
    .START     (START),
    .CONT      (CONT),
    .ABORT     (ABORT),
    .BYTE_HI   (BYTE_HI),
    .WE        (WE),
    .ADDR      (ADDR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .FRAME_CNT (FRAME_CNT)
  );

  // Clock and write monitor
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (WE) got_q.push_back(ADDR);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    repeat (3) tick();
    VSYNC = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int nbytes, input int start_at);
    HREF = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      START = (i == start_at);
      tick();
    end
    START = 1'b0;
    HREF  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_start(input logic cont);
    START = 1'b1;
    CONT  = cont;
    tick();
    START = 1'b0;
    CONT  = 1'b0;
  endtask

  task automatic push_range(input int first, input int last);
    for (int a = first; a <= last; a++) exp_q.push_back(AW'(a));
  endtask

  // Scoreboard comparison of recorded writes against the expected queue
  task automatic sb_compare(input string tag);
    check_eq({tag, "_we_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_addr%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RSTn  = 1'b0;
    VSYNC = 1'b0;
    HREF  = 1'b0;
    START = 1'b0;
    CONT  = 1'b0;
    ABORT = 1'b0;
    #1;
    check_eq("rst_we", WE, 0);
    check_eq("rst_byte_hi", BYTE_HI, 0);
    check_eq("rst_addr", ADDR, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_err", ERR, 0);
    check_eq("rst_fcnt", FRAME_CNT, 0);
    tick();
    tick();
    RSTn = 1'b1;
    tick();

    // Single good frame
    pulse_start(1'b0);
    check_eq("arm_busy", BUSY, 1);
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(8, -1);
    vsync_pulse();
    push_range(0, 11);
    sb_compare("good");
    check_eq("good_done", DONE, 1);
    check_eq("good_err", ERR, 0);
    check_eq("good_busy", BUSY, 0);
    check_eq("good_fcnt", FRAME_CNT, 1);

    // Short second line
    pulse_start(1'b0);
    check_eq("short_start_clr_done", DONE, 0);
    vsync_pulse();
    send_line(8, -1);
    send_line(6, -1);
    send_line(8, -1);
    vsync_pulse();
    push_range(0, 6);
    push_range(8, 11);
    sb_compare("short");
    check_eq("short_err", ERR, 1);
    check_eq("short_done", DONE, 0);
    check_eq("short_fcnt", FRAME_CNT, 1);

    // Extra fourth line
    pulse_start(1'b0);
    check_eq("extra_start_clr_err", ERR, 0);
    vsync_pulse();
    for (int l = 0; l < 4; l++) send_line(8, -1);
    vsync_pulse();
    push_range(0, 11);
    sb_compare("extra");
    check_eq("extra_err", ERR, 1);
    check_eq("extra_fcnt", FRAME_CNT, 1);

    // START in the middle of a frame waits for the next whole frame
    vsync_pulse();
    send_line(8, -1);
    send_line(8, 3);
    check_eq("mid_busy", BUSY, 1);
    send_line(8, -1);
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(8, -1);
    vsync_pulse();
    push_range(0, 11);
    sb_compare("mid");
    check_eq("mid_done", DONE, 1);
    check_eq("mid_fcnt", FRAME_CNT, 2);

    // Continuous mode over two frames, then abort
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    tick();
    ABORT = 1'b1;
    START = 1'b1;
    tick();
    ABORT = 1'b0;
    START = 1'b0;
    check_eq("abort_over_start_busy", BUSY, 0);
    pulse_start(1'b1);
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(8, -1);
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(8, -1);
    vsync_pulse();
    push_range(0, 11);
    push_range(0, 11);
    sb_compare("cont");
    check_eq("cont_fcnt", FRAME_CNT, 2);
    check_eq("cont_busy", BUSY, 1);
    check_eq("cont_done", DONE, 0);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check_eq("abort_busy", BUSY, 0);
    check_eq("abort_done", DONE, 0);
    check_eq("abort_err", ERR, 0);

    // Asynchronous reset in the middle of a line
    pulse_start(1'b0);
    vsync_pulse();
    HREF = 1'b1;
    repeat (3) tick();
    check_eq("pre_rst_we", WE, 1);
    #2;
    RSTn = 1'b0;
    #1;
    check_eq("arst_we", WE, 0);
    check_eq("arst_byte_hi", BYTE_HI, 0);
    check_eq("arst_addr", ADDR, 0);
    check_eq("arst_busy", BUSY, 0);
    check_eq("arst_done", DONE, 0);
    check_eq("arst_err", ERR, 0);
    check_eq("arst_fcnt", FRAME_CNT, 0);
    HREF = 1'b0;
    tick();
    tick();
    RSTn = 1'b1;
    tick();
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(8, -1);
    vsync_pulse();
    exp_q.push_back(AW'(0));
    sb_compare("post_rst");
    check_eq("post_rst_busy", BUSY, 0);
    check_eq("post_rst_fcnt", FRAME_CNT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
